// File: rtl/fclk_align_ctrl.sv
// fclk_align_ctrl: bitslip alignment controller for the ADC frame-clock deserializer.
//
// Ports (all in the divclk domain):
//    divclk       deserializer divided clock
//    rst_n        asynchronous active-low reset
//    start        single-cycle request to begin or restart alignment
//    fclk_deser   deserialized 8-bit frame-clock word
//    bitslip      one-cycle bitslip pulse to both deserializer halves
//    busy         high while checking, slipping or settling
//    locked       high while the frame word is held in alignment
//    fail         high when alignment gave up after MAX_SLIPS slips
//    slip_count   bitslips issued in the current attempt
//    relock_count saturating count of lock losses
//
// Optional macro FCLK_ALIGN_STATS_EN: implements relock_count plus an internal
// saturating total-bitslip counter (slip_total) for on-chip debug probing.
// Without it relock_count reads 8'h00.
module fclk_align_ctrl #(
   parameter logic [7:0] PATTERN       = 8'hF0,
   parameter int         SETTLE_CYCLES = 4,
   parameter int         MAX_SLIPS     = 8,
   parameter int         LOCK_COUNT    = 16,
   parameter int         LOSS_COUNT    = 4
) (
   input  logic       divclk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] fclk_deser,
   output logic       bitslip,
   output logic       busy,
   output logic       locked,
   output logic       fail,
   output logic [3:0] slip_count,
   output logic [7:0] relock_count
);
   typedef enum logic [2:0] {IDLE, CHECK, SLIP, SETTLE, LOCKED, FAIL} state_t;
   state_t     state;
   logic [7:0] match_cnt;
   logic [3:0] miss_cnt;
   logic [3:0] settle_cnt;
   logic       match;
   logic       loss_evt;
   logic       restart;
   assign match    = fclk_deser == PATTERN;
   // an explicit start wins over a coincident loss of lock
   assign loss_evt = state == LOCKED && !start && !match && miss_cnt == 4'(LOSS_COUNT - 1);
   assign restart  = loss_evt || (start && (state == IDLE || state == LOCKED || state == FAIL));
   always_ff @(posedge divclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bitslip    <= 1'b0;
         busy       <= 1'b0;
         locked     <= 1'b0;
         fail       <= 1'b0;
         slip_count <= 4'd0;
         match_cnt  <= 8'd0;
         miss_cnt   <= 4'd0;
         settle_cnt <= 4'd0;
      end else begin
         bitslip <= 1'b0;
         if (restart) begin
            state      <= CHECK;
            busy       <= 1'b1;
            locked     <= 1'b0;
            fail       <= 1'b0;
            slip_count <= 4'd0;
            match_cnt  <= 8'd0;
            miss_cnt   <= 4'd0;
         end else begin
            case (state)
               CHECK:
                  if (match) begin
                     match_cnt <= match_cnt + 8'd1;
                     if (match_cnt == 8'(LOCK_COUNT - 1)) begin
                        state    <= LOCKED;
                        busy     <= 1'b0;
                        locked   <= 1'b1;
                        miss_cnt <= 4'd0;
                     end
                  end else if (slip_count == 4'(MAX_SLIPS)) begin
                     state <= FAIL;
                     busy  <= 1'b0;
                     fail  <= 1'b1;
                  end else begin
                     // bitslip is registered, so it is high exactly while in SLIP
                     state     <= SLIP;
                     bitslip   <= 1'b1;
                     match_cnt <= 8'd0;
                  end
               SLIP: begin
                  state      <= SETTLE;
                  slip_count <= slip_count + 4'd1;
                  settle_cnt <= 4'd0;
               end
               SETTLE:
                  if (settle_cnt == 4'(SETTLE_CYCLES - 1)) begin
                     state     <= CHECK;
                     match_cnt <= 8'd0;
                  end else begin
                     settle_cnt <= settle_cnt + 4'd1;
                  end
               LOCKED:
                  miss_cnt <= match ? 4'd0 : miss_cnt + 4'd1;
               default: ;
            endcase
         end
      end
   end
`ifdef FCLK_ALIGN_STATS_EN
   logic [7:0] relock_q;
   logic [7:0] slip_total;
   always_ff @(posedge divclk or negedge rst_n) begin
      if (!rst_n) begin
         relock_q   <= 8'd0;
         slip_total <= 8'd0;
      end else begin
         if (loss_evt && relock_q != 8'hFF)
            relock_q <= relock_q + 8'd1;
         if (state == SLIP && slip_total != 8'hFF)
            slip_total <= slip_total + 8'd1;
      end
   end
   assign relock_count = relock_q;
`else
   assign relock_count = 8'h00;
`endif
endmodule

// File: tb/tb_fclk_align_ctrl.sv
// tb_fclk_align_ctrl: self-checking bench for fclk_align_ctrl with a rotating deserializer model.
module tb_fclk_align_ctrl;
   localparam logic [7:0] PAT = 8'hF0;
   localparam int SC  = 4;
   localparam int MS  = 8;
   localparam int LC  = 16;
   localparam int LSC = 4;
`ifdef FCLK_ALIGN_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   logic       divclk = 1'b0;
   logic       rst_n  = 1'b0;
   logic       start  = 1'b0;
   logic [7:0] fclk_deser;
   logic       bitslip, busy, locked, fail;
   logic [3:0] slip_count;
   logic [7:0] relock_count;
   int         off = 0;
   bit         noise = 1'b0;
   bit         ovr = 1'b0;
   logic [7:0] ovr_w = 8'h00;
   bit         pend = 1'b0;
   int         ncyc, np, last_p, min_gap, max_gap;
   int         tests = 0;
   int         fails = 0;
   int         exp_relock = 0;

   typedef struct {
      int off;
      bit nz;
      bit poke;
      int exp_cyc;
      int exp_np;
      int exp_slip;
      bit exp_lock;
      bit exp_fail;
   } vec_t;
   vec_t tbl[6];

   always #5 divclk = ~divclk;

   function automatic logic [7:0] rotr(input logic [7:0] v, input int k);
      logic [15:0] d;
      d = {v, v} >> (k % 8);
      return d[7:0];
   endfunction

   // deserializer model: word is PATTERN rotated right by the remaining offset;
   // each bitslip rotates it left by one (offset decreases)
   assign fclk_deser = ovr ? ovr_w : noise ? 8'hAA : rotr(PAT, off);

   fclk_align_ctrl dut (
      .divclk(divclk), .rst_n(rst_n), .start(start), .fclk_deser(fclk_deser),
      .bitslip(bitslip), .busy(busy), .locked(locked), .fail(fail),
      .slip_count(slip_count), .relock_count(relock_count)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // one clock; the slip requested by a pulse seen last cycle takes effect now
   task automatic tick();
      int gap;
      @(posedge divclk);
      #1;
      if (pend) off = (off + 7) % 8;
      pend = bitslip;
      ncyc++;
      if (bitslip) begin
         if (last_p >= 0) begin
            gap = ncyc - last_p;
            if (gap < min_gap) min_gap = gap;
            if (gap > max_gap) max_gap = gap;
         end
         last_p = ncyc;
         np++;
      end
   endtask

   task automatic clear_stats();
      np = 0; last_p = -1; min_gap = 999; max_gap = 0; ncyc = 0;
   endtask

   task automatic run_attempt(input int off_i, input bit nz, input bit poke, output int cyc);
      off = off_i; noise = nz; ovr = 1'b0;
      clear_stats();
      start = 1'b1;
      tick();
      start = 1'b0;
      while (!locked && !fail && ncyc < 400) begin
         start = poke && busy && ($urandom_range(0, 2) == 0);
         tick();
      end
      start = 1'b0;
      cyc = ncyc;
   endtask

   task automatic relock_wait(output int n);
      ovr = 1'b0;
      n = 0;
      while (!locked && n < 100) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int cyc, n, k, run;
      bit m, dropped;
      tbl[0] = '{3, 1'b0, 1'b0, 3*(SC+2)+LC+1, 3, 3, 1'b1, 1'b0};
      tbl[1] = '{0, 1'b0, 1'b0, LC+1,          0, 0, 1'b1, 1'b0};
      tbl[2] = '{0, 1'b1, 1'b0, MS*(SC+2)+2,  MS, MS, 1'b0, 1'b1};
      tbl[3] = '{7, 1'b0, 1'b0, 7*(SC+2)+LC+1, 7, 7, 1'b1, 1'b0};
      tbl[4] = '{3, 1'b0, 1'b1, 3*(SC+2)+LC+1, 3, 3, 1'b1, 1'b0};
      tbl[5] = '{1, 1'b0, 1'b0, 1*(SC+2)+LC+1, 1, 1, 1'b1, 1'b0};
      clear_stats();
      repeat (2) @(posedge divclk);
      #1;
      check("rst_bitslip", bitslip, 0);
      check("rst_busy", busy, 0);
      check("rst_locked", locked, 0);
      check("rst_fail", fail, 0);
      check("rst_slip_count", slip_count, 0);
      check("rst_relock", relock_count, 0);
      @(negedge divclk) rst_n = 1'b1;

      foreach (tbl[i]) begin
         run_attempt(tbl[i].off, tbl[i].nz, tbl[i].poke, cyc);
         check($sformatf("vec%0d_cycles", i), cyc, tbl[i].exp_cyc);
         check($sformatf("vec%0d_pulses", i), np, tbl[i].exp_np);
         check($sformatf("vec%0d_slip_count", i), slip_count, tbl[i].exp_slip);
         check($sformatf("vec%0d_locked", i), locked, tbl[i].exp_lock);
         check($sformatf("vec%0d_fail", i), fail, tbl[i].exp_fail);
         if (tbl[i].exp_np > 1) begin
            check($sformatf("vec%0d_min_gap", i), min_gap, SC + 2);
            check($sformatf("vec%0d_max_gap", i), max_gap, SC + 2);
         end
      end

      repeat (6) begin
         k = $urandom_range(0, 7);
         run_attempt(k, 1'b0, $urandom_range(0, 1), cyc);
         check($sformatf("rnd_off%0d_cycles", k), cyc, k*(SC+2) + LC + 1);
         check($sformatf("rnd_off%0d_pulses", k), np, k);
         check($sformatf("rnd_off%0d_slip_count", k), slip_count, k);
         check($sformatf("rnd_off%0d_locked", k), locked, 1);
      end

      // lock loss: 3 mismatches, a match, then 4 mismatches
      for (int i = 0; i < 8; i++) begin
         ovr = 1'b1;
         ovr_w = (i == 3) ? PAT : 8'h0F;
         tick();
         check($sformatf("loss_step%0d_locked", i), locked, (i == 7) ? 0 : 1);
      end
      check("loss_busy", busy, 1);
      check("loss_slip_count", slip_count, 0);
      exp_relock++;
      check("loss_relock", relock_count, STATS ? exp_relock : 0);
      relock_wait(n);
      check("relock_cycles", n, LC);
      check("relock_locked", locked, 1);

      // random match/mismatch streams against a run-length loss model
      run = 0;
      repeat (5) begin
         dropped = 1'b0;
         for (int j = 0; j < 20 && !dropped; j++) begin
            m = $urandom_range(0, 9) < 4;
            ovr = 1'b1;
            ovr_w = $urandom_range(0, 255);
            if (!m) ovr_w = PAT;
            else if (ovr_w == PAT) ovr_w = ~PAT;
            run = m ? run + 1 : 0;
            tick();
            if (run == LSC) begin
               dropped = 1'b1;
               run = 0;
               exp_relock++;
               check("rloss_drop", locked, 0);
               check("rloss_relock", relock_count, STATS ? exp_relock : 0);
               relock_wait(n);
               check("rloss_relock_cycles", n, LC);
            end else begin
               check("rloss_hold", locked, 1);
            end
         end
         ovr = 1'b0;
         tick();
         run = 0;
         check("rloss_tail_locked", locked, 1);
      end

      // asynchronous reset while settling after the first slip
      off = 3; noise = 1'b0; ovr = 1'b0;
      clear_stats();
      start = 1'b1;
      tick();
      start = 1'b0;
      while (np == 0 && ncyc < 50) tick();
      tick();
      tick();
      check("settle_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_bitslip", bitslip, 0);
      check("arst_busy", busy, 0);
      check("arst_slip_count", slip_count, 0);
      check("arst_relock", relock_count, 0);
      exp_relock = 0;
      repeat (2) @(posedge divclk);
      #1;
      check("arst_hold_busy", busy, 0);
      @(negedge divclk) rst_n = 1'b1;
      clear_stats();
      repeat (8) tick();
      check("idle_no_pulse", np, 0);
      check("idle_busy", busy, 0);
      check("idle_locked", locked, 0);
      check("idle_fail", fail, 0);
      run_attempt(off, 1'b0, 1'b0, cyc);
      check("post_rst_off", off, 0);
      check("post_rst_pulses", np, 2);
      check("post_rst_cycles", cyc, 2*(SC+2) + LC + 1);
      check("post_rst_locked", locked, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fclk_align_ctrl.md
Name: fclk_align_ctrl

Overview:
- Bitslip alignment controller for the ADC frame-clock deserializer.
- Monitors the 8-bit deserialized frame-clock word and issues single-cycle bitslip pulses until the word matches the expected frame pattern.
- Holds lock, detects loss of lock and re-aligns. Reports lock and failure status to the capture logic.
- Runs entirely in the deserializer divided-clock domain.

Parameters:
- PATTERN, 8'hF0, expected deserialized frame-clock word when aligned.
- SETTLE_CYCLES, 4, divclk cycles to wait after each bitslip before comparing again (range 1-15).
- MAX_SLIPS, 8, maximum bitslips per alignment attempt before declaring failure (range 1-15).
- LOCK_COUNT, 16, consecutive matching words required to declare lock (range 1-255).
- LOSS_COUNT, 4, consecutive mismatching words in LOCKED that drop lock (range 1-15).

Ports:
- divclk  input  1  deserializer divided clock; only clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin or restart alignment.
- fclk_deser  input  8  deserialized frame-clock word.
- bitslip  output  1  one-cycle bitslip pulse to both deserializer halves.
- busy  output  1  high while in CHECK, SLIP or SETTLE.
- locked  output  1  high only in LOCKED.
- fail  output  1  high only in FAIL.
- slip_count  output  4  bitslips issued in the current attempt.
- relock_count  output  8  saturating count of lock losses (see optional feature).

Behaviour:
- Reset is asynchronous on rst_n low. State goes to IDLE. bitslip, busy, locked and fail are 0. slip_count, relock_count and all internal counters are 0.
- All outputs are registered.
- States: IDLE, CHECK, SLIP, SETTLE, LOCKED, FAIL.
- IDLE:
  - Outputs inactive.
  - start goes to CHECK next cycle; slip_count, match counter and mismatch counter are cleared.
- CHECK, once per cycle:
  - Compare fclk_deser with PATTERN.
  - Match: increment the 8-bit match counter. When the counter reaches LOCK_COUNT, go to LOCKED; locked is asserted the cycle after the LOCK_COUNT-th consecutive match.
  - Mismatch with slip_count < MAX_SLIPS: clear the match counter and go to SLIP.
  - Mismatch with slip_count == MAX_SLIPS: go to FAIL.
- SLIP (one cycle):
  - bitslip = 1 for exactly this cycle.
  - slip_count increments.
  - Go to SETTLE.
- SETTLE:
  - Hold for SETTLE_CYCLES cycles, ignoring fclk_deser.
  - Then go to CHECK with the match counter cleared.
- LOCKED:
  - Each mismatch increments the mismatch counter; each match clears it.
  - When the counter reaches LOSS_COUNT: deassert locked the next cycle, increment relock_count (saturating at 255), clear slip_count and the counters, and go to CHECK.
- FAIL:
  - fail = 1.
  - Stay in FAIL until start.
- start handling:
  - start in LOCKED or FAIL restarts: counters cleared, go to CHECK, and locked/fail drop the next cycle.
  - start while busy is ignored.
- Timing: bitslip is never asserted on consecutive cycles; the minimum spacing between pulses is SETTLE_CYCLES+2.
- Worst-case attempt before FAIL: MAX_SLIPS*(SETTLE_CYCLES+2)+1 cycles from entering CHECK.
- A mid-operation rst_n low aborts immediately. bitslip drops asynchronously, so no partial pulse is extended.

Optional Feature:
- FCLK_ALIGN_STATS_EN defined: relock_count is implemented as described.
- Also defined: a second 8-bit saturating counter counts total bitslips since reset. It is readable only internally, for ChipScope.
- Not defined: relock_count is tied to 8'h00, and neither counter exists.

Test Plan:
- Deserializer model rotates PATTERN left by one per bitslip, initial offset 3, start pulse:
  - exactly 3 bitslip pulses, each separated by 6 cycles;
  - slip_count = 3;
  - locked asserted after 16 matching words;
  - fail = 0.
- Initial offset 0, start:
  - no bitslip;
  - locked asserted 17 cycles after start;
  - slip_count = 0.
- Model never produces PATTERN (constant 8'hAA), start:
  - 8 bitslips;
  - fail = 1, locked = 0, slip_count = 8.
- While locked, inject 3 mismatches then a match, then 4 consecutive mismatches:
  - lock held after the 3;
  - locked drops after the 4th;
  - relock_count = 1 (macro defined) or 0 (undefined);
  - re-alignment completes with locked = 1.
- rst_n low for 2 cycles during SETTLE:
  - all outputs 0 immediately;
  - state IDLE;
  - no bitslip until the next start.
- start asserted while busy:
  - ignored, with slip sequence and slip_count identical to an undisturbed run.
